// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: digit code width and
// active-high segment patterns in {a,b,c,d,e,f,g} order.
package seg7_pkg;
  localparam int CODE_W = 4;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-high segment pattern; codes 10..15 only light in hex mode.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              hex_mode,
  output logic [6:0]        pattern
);
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: pattern = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: pattern = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: pattern = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: pattern = hex_mode ? SEG_E : SEG_BLANK;
      default: pattern = hex_mode ? SEG_F : SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous shadow
// update, leading-zero blanking, anti-ghost blank slot and output polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CODE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic                         lzb_en,
  input  logic                         load,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [NUM_DIGITS-1:0]        dig,
  output logic                         frame_tick
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick_q, pending_q, pending_d;
  logic          presc_wrap, frame_wrap;

  logic [NUM_DIGITS-1:0][CODE_W-1:0] shd_val_q, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]             shd_dp_q, act_dp_q, act_dp_d;
  logic                              shd_lzb_q, act_lzb_q, act_lzb_d;

  logic [NUM_DIGITS-1:0][6:0] pat;
  logic [NUM_DIGITS-1:0]      blank_mask;
  logic                       zeros_above;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [NUM_DIGITS-1:0]      dig_q, dig_d;

  assign presc_wrap = (presc_q == PW'(CLK_DIV - 1));
  assign frame_wrap = presc_wrap && (idx_q == IW'(NUM_DIGITS - 1));
  assign presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
  assign idx_d      = !presc_wrap ? idx_q : (frame_wrap ? '0 : idx_q + 1'b1);
  assign pending_d  = load ? 1'b1 : (tick_q ? 1'b0 : pending_q);

  // The output register samples the post-transfer active set, so the first
  // digit-0 slot of a frame already shows new data even with no blank time.
  always_comb begin
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_lzb_d = act_lzb_q;
    if (tick_q && pending_q) begin
      act_val_d = shd_val_q;
      act_dp_d  = shd_dp_q;
      act_lzb_d = shd_lzb_q;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .code     (act_val_d[g]),
      .hex_mode (HEX_MODE != 0),
      .pattern  (pat[g])
    );
  end

  always_comb begin
    blank_mask  = '0;
    zeros_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros_above   = zeros_above && (act_val_d[k] == '0);
      blank_mask[k] = act_lzb_d && zeros_above;
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    dig_d = DIG_OFF;
    if (presc_q >= PW'(BLANK_CYCLES)) begin
      dig_d[idx_q] = ~DIG_OFF[idx_q];
      seg_d        = blank_mask[idx_q] ? SEG_OFF
                   : ((SEG_ACTIVE_LOW != 0) ? ~pat[idx_q] : pat[idx_q]);
      dp_d         = act_dp_d[idx_q] ^ DP_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      shd_lzb_q <= 1'b0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_lzb_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      tick_q    <= frame_wrap;
      pending_q <= pending_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_lzb_q <= act_lzb_d;
      if (load) begin
        shd_val_q <= value;
        shd_dp_q  <= dp_in;
        shd_lzb_q <= lzb_en;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig        = dig_q;
  assign frame_tick = tick_q;
endmodule
